// File: rtl/wb_pkg.sv
// Shared types and defaults for the write-back stage: FSM state encoding,
// datapath defaults and the register-index width helper.
package wb_pkg;

  localparam int WORD_LEN_DEF   = 32;
  localparam int WORD_COUNT_DEF = 15;
  localparam int CNT_W_DEF      = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    WAIT_MEM = 2'd2
  } wb_state_t;

  // Index width for a register file of 'count' entries; never narrower than one bit.
  function automatic int regIdxW(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  localparam int REG_IDX_W_DEF = regIdxW(WORD_COUNT_DEF);

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB retire handshake: one instruction per in_valid & in_ready transfer.
// master = MEM stage side, slave = write-back stage side.
interface wb_stage_if
  import wb_pkg::*;
#(
  parameter int WORD_LEN   = WORD_LEN_DEF,
  parameter int WORD_COUNT = WORD_COUNT_DEF
) ();

  localparam int IDX_W = regIdxW(WORD_COUNT);

  logic                in_valid;
  logic                in_ready;
  logic                in_wb_en;
  logic                in_mem_r_en;
  logic [IDX_W-1:0]    in_dest;
  logic [WORD_LEN-1:0] in_alu_result;

  modport master (
    output in_valid,
    output in_wb_en,
    output in_mem_r_en,
    output in_dest,
    output in_alu_result,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_wb_en,
    input  in_mem_r_en,
    input  in_dest,
    input  in_alu_result,
    output in_ready
  );

endinterface

// File: rtl/wb_retire_counter.sv
// Free-running retire counter: increments once per enabled cycle and wraps
// modulo 2^CNT_W. Synchronous active-low reset.
module wb_retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires one instruction per cycle, waits for load data and
// drives the register-file write port. Optional feature macro: WB_FORWARD_EN.
module wb_stage
  import wb_pkg::*;
#(
  parameter int WORD_LEN   = WORD_LEN_DEF,
  parameter int WORD_COUNT = WORD_COUNT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  wb_stage_if.slave                        inBus,
  input  logic [WORD_LEN-1:0]              mem_rdata,
  input  logic                             mem_rvalid,
  input  logic                             flush,
  output logic [regIdxW(WORD_COUNT)-1:0]   rf_write_reg,
  output logic [WORD_LEN-1:0]              rf_write_data,
  output logic                             rf_reg_write,
  output logic [CNT_W-1:0]                 retire_cnt,
  output logic                             fwd_valid,
  output logic [regIdxW(WORD_COUNT)-1:0]   fwd_dest,
  output logic [WORD_LEN-1:0]              fwd_data
);

  localparam int IDX_W = regIdxW(WORD_COUNT);
  localparam logic [IDX_W:0] COUNT_L = WORD_COUNT[IDX_W:0];

  wb_state_t        state;
  logic [IDX_W-1:0] pendDest_p1;
  logic             pendWbEn_p1;
  logic             takeNow;

  // Destinations beyond the architectural file retire silently.
  function automatic logic commitOk(input logic wbEn, input logic [IDX_W-1:0] dest);
    return wbEn && ({1'b0, dest} < COUNT_L);
  endfunction

  assign inBus.in_ready = (state != WAIT_MEM);

  // A transfer completes immediately unless it is a load whose data is not here yet.
  assign takeNow = !inBus.in_mem_r_en || mem_rvalid;

  // ---- stage p1: FSM, pending-load capture and registered write port ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      rf_reg_write  <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
    end else begin
      rf_reg_write <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, WRITE: begin
            if (inBus.in_valid) begin
              if (takeNow) begin
                state <= WRITE;
                if (commitOk(inBus.in_wb_en, inBus.in_dest)) begin
                  rf_reg_write  <= 1'b1;
                  rf_write_reg  <= inBus.in_dest;
                  rf_write_data <= inBus.in_mem_r_en ? mem_rdata : inBus.in_alu_result;
                end
              end else begin
                state       <= WAIT_MEM;
                pendDest_p1 <= inBus.in_dest;
                pendWbEn_p1 <= inBus.in_wb_en;
              end
            end else begin
              state <= IDLE;
            end
          end
          WAIT_MEM: begin
            if (mem_rvalid) begin
              state <= WRITE;
              if (commitOk(pendWbEn_p1, pendDest_p1)) begin
                rf_reg_write  <= 1'b1;
                rf_write_reg  <= pendDest_p1;
                rf_write_data <= mem_rdata;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  wb_retire_counter #(
    .CNT_W (CNT_W)
  ) uRetire (
    .clk   (clk),
    .rst   (rst),
    .en    (rf_reg_write),
    .count (retire_cnt)
  );

`ifdef WB_FORWARD_EN
  assign fwd_valid = rf_reg_write;
  assign fwd_dest  = rf_write_reg;
  assign fwd_data  = rf_write_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_dest  = '0;
  assign fwd_data  = '0;
`endif

endmodule
